// File: rtl/acc_dout_pkg.sv
// Shared types and width helpers for the accelerator output router.
package acc_dout_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} dout_state_t;
  typedef enum logic {SPLIT, DUAL} dout_mode_t;

  // Bits needed to hold a count from 0 to n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/acc_bank_writer.sv
// One output bank: address counter, quota check, sticky overflow and the
// registered BRAM write port.
module acc_bank_writer
  import acc_dout_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 14,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CNT_W-1:0]  quota,
  output logic              wea,
  output logic [ADDR_W-1:0] addra,
  output logic [DATA_W-1:0] dina,
  output logic              overflow,
  output logic              met
);

  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  cnt;

  // clear wins over a beat in flight so a new stage starts with nothing written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wea      <= 1'b0;
      addra    <= '0;
      dina     <= '0;
      overflow <= 1'b0;
      addr     <= '0;
      cnt      <= '0;
    end else if (clear) begin
      wea      <= 1'b0;
      addra    <= '0;
      dina     <= '0;
      overflow <= 1'b0;
      addr     <= '0;
      cnt      <= '0;
    end else begin
      wea <= 1'b0;
      if (in_valid) begin
        if (cnt < quota) begin
          wea   <= 1'b1;
          addra <= addr;
          dina  <= in_data;
          addr  <= addr + ADDR_W'(1);
          cnt   <= cnt + CNT_W'(1);
        end else begin
          overflow <= 1'b1;
        end
      end
    end
  end

  assign met = (cnt >= quota);

endmodule

// File: rtl/acc_dout_router.sv
// Routes full/tiny accelerator result lanes into 2*LANES output BRAM banks,
// with the SPLIT/DUAL stage mode latched on the stage_start rising edge.
module acc_dout_router
  import acc_dout_pkg::*;
#(
  parameter int LANES     = 8,
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 14,
  parameter int DATA_NUM  = 768,
  parameter int TINY_NUM  = 768,
  parameter int SPLIT_CFG = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              stage_start,
  input  logic [31:0]                       configs,
  input  logic [LANES-1:0][DATA_W-1:0]      full_tdata,
  input  logic [LANES-1:0]                  full_tvalid,
  input  logic [LANES-1:0][DATA_W-1:0]      tiny_tdata,
  input  logic [LANES-1:0]                  tiny_tvalid,
  output logic [2*LANES-1:0]                bram_wea,
  output logic [2*LANES-1:0][ADDR_W-1:0]    bram_addra,
  output logic [2*LANES-1:0][DATA_W-1:0]    bram_dina,
  output logic                              busy,
  output logic [2*LANES-1:0]                overflow,
  output logic                              stage_done
);

  localparam int NB     = 2 * LANES;
  localparam int BEAT_W = cnt_width(DATA_NUM);
  localparam int Q_W    = cnt_width((DATA_NUM > TINY_NUM) ? DATA_NUM : TINY_NUM);

  localparam logic [BEAT_W-1:0] BEAT_MAX  = BEAT_W'(DATA_NUM);
  localparam logic [BEAT_W-1:0] BEAT_HALF = BEAT_W'(DATA_NUM / 2);
  localparam logic [Q_W-1:0]    Q_HALF    = Q_W'(DATA_NUM / 2);
  localparam logic [Q_W-1:0]    Q_FULL    = Q_W'(DATA_NUM);
  localparam logic [Q_W-1:0]    Q_TINY    = Q_W'(TINY_NUM);

  dout_state_t state, state_next;
  dout_mode_t  mode;

  logic                      stage_start_q;
  logic                      start_pulse;
  logic                      accept;
  logic [BEAT_W-1:0]         beat_cnt;
  logic [NB-1:0]             route_v;
  logic [NB-1:0][DATA_W-1:0] route_d;
  logic [NB-1:0]             cap_v;
  logic [NB-1:0][DATA_W-1:0] cap_d;
  logic [NB-1:0][Q_W-1:0]    bank_quota;
  logic [NB-1:0]             bank_met;

  assign start_pulse = stage_start & ~stage_start_q;
  assign accept      = (state == RUN) && !start_pulse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_start_q <= 1'b0;
      mode          <= SPLIT;
      beat_cnt      <= '0;
    end else begin
      stage_start_q <= stage_start;
      if (start_pulse) begin
        mode     <= (configs <= 32'(SPLIT_CFG)) ? SPLIT : DUAL;
        beat_cnt <= '0;
      end else if (accept && full_tvalid[0] && (beat_cnt != BEAT_MAX)) begin
        beat_cnt <= beat_cnt + BEAT_W'(1);
      end
    end
  end

  // The SPLIT half decision uses the beat count before this beat is counted.
  always_comb begin
    route_v = '0;
    route_d = '0;
    for (int i = 0; i < LANES; i++) begin
      if (mode == SPLIT) begin
        if (beat_cnt < BEAT_HALF) begin
          route_v[i] = full_tvalid[i];
          route_d[i] = full_tdata[i];
        end else begin
          route_v[LANES+i] = full_tvalid[i];
          route_d[LANES+i] = full_tdata[i];
        end
      end else begin
        route_v[i]       = full_tvalid[i];
        route_d[i]       = full_tdata[i];
        route_v[LANES+i] = tiny_tvalid[i];
        route_d[LANES+i] = tiny_tdata[i];
      end
    end
    if (!accept) route_v = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_v <= '0;
      cap_d <= '0;
    end else begin
      cap_v <= route_v;
      cap_d <= route_d;
    end
  end

  always_comb begin
    bank_quota = '0;
    for (int b = 0; b < NB; b++) begin
      if (mode == SPLIT)  bank_quota[b] = Q_HALF;
      else if (b < LANES) bank_quota[b] = Q_FULL;
      else                bank_quota[b] = Q_TINY;
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_bank
    acc_bank_writer #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .CNT_W  (Q_W)
    ) u_bank (
      .clk      (clk),
      .rst      (rst),
      .clear    (start_pulse),
      .in_valid (cap_v[b]),
      .in_data  (cap_d[b]),
      .quota    (bank_quota[b]),
      .wea      (bram_wea[b]),
      .addra    (bram_addra[b]),
      .dina     (bram_dina[b]),
      .overflow (overflow[b]),
      .met      (bank_met[b])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start_pulse) begin
      state_next = RUN;
    end else begin
      case (state)
        IDLE:    state_next = IDLE;
        RUN:     if (&bank_met) state_next = DONE;
        DONE:    state_next = DONE;
        default: state_next = IDLE;
      endcase
    end
  end

  assign busy       = (state == RUN);
  assign stage_done = (state == DONE);

endmodule

// File: doc/acc_dout_router.md
# acc_dout_router

Parametrised accelerator-output router that moves per-lane result beats from the full and tiny compute streams into 2×LANES banked output BRAM write ports. It sits between the accelerator array and the output BRAMs, replacing the fixed 8-lane/64-bit transfer stage. The stage mode is latched at stage start. Each bank keeps its own address counter and beat quota, and the block reports per-bank overflow and a single `stage_done`.

## Interface
- `LANES`, 8: stream lanes per source. Bank count is 2×LANES.
- `DATA_W`, 64: beat and BRAM data width.
- `ADDR_W`, 14: BRAM address width.
- `DATA_NUM`, 768: full-stream beats per stage. Must be even and ≤ 2^ADDR_W.
- `TINY_NUM`, 768: tiny-stream beats per stage in DUAL mode. Must be ≤ 2^ADDR_W.
- `SPLIT_CFG`, 2: if `configs` ≤ SPLIT_CFG the stage is SPLIT mode, otherwise it is DUAL mode.

- `clk` in 1: the only clock.
- `rst` in 1: asynchronous reset, active-high.
- `stage_start` in 1: level. Its rising edge starts a stage.
- `configs` in 32: stage configuration. Sampled on the start edge.
- `full_tdata` in DATA_W ×[LANES]: full-stream beat per lane.
- `full_tvalid` in 1 ×[LANES]: full-stream valid per lane. There is no ready; the block always accepts.
- `tiny_tdata` in DATA_W ×[LANES]: tiny-stream beat per lane.
- `tiny_tvalid` in 1 ×[LANES]: tiny-stream valid per lane.
- `bram_wea` out 1 ×[2·LANES]: per-bank write enable.
- `bram_addra` out ADDR_W ×[2·LANES]: per-bank write address.
- `bram_dina` out DATA_W ×[2·LANES]: per-bank write data.
- `busy` out 1: stage in progress.
- `overflow` out 1 ×[2·LANES]: sticky per bank. Set when a beat arrives after that bank's quota is met.
- `stage_done` out 1: all banks have met their quotas.

## Operation
- **Start edge:** `start_pulse = stage_start & ~stage_start_q`. A start pulse in any state does the following:
  - clears all beat counters, bank addresses and `overflow`;
  - latches `mode = (configs <= SPLIT_CFG) ? SPLIT : DUAL`;
  - enters RUN.
- **FSM states:**
  - IDLE → RUN on `start_pulse`.
  - RUN → DONE when every bank's quota is met.
  - DONE holds until the next `start_pulse`.
  - No other transitions. Beats are ignored in IDLE and DONE.
- **Beat counter:** `beat_cnt` (clog2(DATA_NUM+1) bits) increments on `full_tvalid[0]` in RUN and saturates at DATA_NUM.
- **SPLIT mode:**
  - Full lane i is routed to bank i while `beat_cnt` < DATA_NUM/2, and to bank LANES+i after that.
  - Tiny inputs are ignored.
  - Quota is DATA_NUM/2 for every bank.
- **DUAL mode:**
  - Full lane i is routed to bank i with quota DATA_NUM.
  - Tiny lane i is routed to bank LANES+i with quota TINY_NUM.
- **Bank writer:** for each routed valid beat, while the bank is under quota:
  - write at the current address;
  - then increment the address (ADDR_W bits, starting at 0);
  - then increment the bank count.
- **Over quota:** a beat arriving when the bank is already at quota is dropped (no `wea`) and sets `overflow[bank]`.
- **Done:** `stage_done` = FSM in DONE.
- **Reset:** `rst` asserted at any time, including mid-stage, asynchronously forces IDLE. All counters, outputs and `stage_start_q` go to 0. A `stage_start` already high when `rst` releases starts a stage on the first clock edge.

## Timing
- **Reset values:** `bram_wea`, `bram_addra`, `bram_dina`, `busy`, `overflow` and `stage_done` are all 0.
- **Input registering:** inputs are registered once (stage 1). The routing decision uses `beat_cnt` at the moment of capture.
- **Write latency:** the BRAM write is registered (stage 2). Beat captured at edge N → `wea`/`addra`/`dina` valid after edge N+1.
- **Start latency:** `busy` rises one cycle after the start edge is sampled.
- **Done latency:** `stage_done` rises one cycle after the last quota-completing write is presented. It stays high until the next `start_pulse`, which clears it on the same edge that enters RUN.
- **SPLIT boundary:** beat index DATA_NUM/2−1 goes to the lower banks; beat index DATA_NUM/2 goes to the upper banks. There is no idle cycle between them.
- **Simultaneous events:**
  - `start_pulse` together with a valid beat: the beat is dropped and the new stage starts clean.
  - Quota met on the same cycle as a new beat for that bank: the write completes and there is no overflow.

## Structure
- **Package `acc_dout_pkg`:**
  - `typedef enum logic [1:0] {IDLE, RUN, DONE} dout_state_t`
  - `typedef enum logic {SPLIT, DUAL} dout_mode_t`
  - a `clog2`-based width helper
- **Sub-module `acc_bank_writer`:** one instance per bank (2·LANES instances). It contains the address counter, quota comparator, overflow flag and output register, with `quota` as a runtime input.

## Test plan
- **SPLIT, configs=1, LANES=8, DATA_NUM=768:** 768 consecutive full beats, data = {lane, beat}.
  - Banks 0–7 receive beats 0–383 at addresses 0–383.
  - Banks 8–15 receive beats 384–767 at addresses 0–383.
  - `stage_done` rises 2 cycles after the last beat.
  - No overflow.
- **DUAL, configs=5:** 768 full beats interleaved with gaps, and 768 tiny beats with independent gaps.
  - Banks 0–7 get full data at addresses 0–767.
  - Banks 8–15 get tiny data.
  - Done only after both streams complete.
- **Overflow:** SPLIT mode with 770 beats.
  - Beats 768 and 769 are dropped.
  - `overflow[8..15]` = 1, `overflow[0..7]` = 0.
  - `stage_done` still high.
- **Restart:** `stage_start` dropped and re-raised at beat 100.
  - Counters and addresses restart at 0.
  - The mode is re-latched from the new `configs` value.
  - The coincident beat is not written.
- **Async reset at beat 200:**
  - All outputs are 0 immediately, without a clock edge.
  - After release with `stage_start` high, a full stage completes normally.
- **Boundary:** at the SPLIT half-point, beats 383 and 384 land on consecutive cycles in bank 0 at address 383 and bank 8 at address 0.
